output_stream_buffer: RTL and testbench
=======================================

# output_stream_buffer

Elastic buffer between the accelerator output port (`cpu_wrapper` output stream) and the HWPE streamer that writes results to L1/TCDM. The accelerator asserts output-valid with no back-pressure, so this block absorbs the beats in a small FIFO and replays them on a ready/valid source. It also counts the beats delivered for a job against a programmed total, raises a one-cycle `done` pulse, and reports a sticky overflow when the FIFO had to drop a beat.

## Interface
- `DATA_WIDTH`, default 32: beat width; equals 4 x 8-bit activations.
- `DEPTH`, default 8: FIFO entries; power of two, minimum 2.
- `CNT_WIDTH`, default 16: width of the beat counters.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `clear`  in  1  synchronous clear: empties the FIFO, zeroes the counters, clears `overflow`, and returns the FSM to IDLE.
- `start`  in  1  job start; sampled only in IDLE.
- `expected_beats`  in  CNT_WIDTH  number of output beats in the job; latched on an accepted `start`.
- `in_valid`  in  1  accelerator output enable.
- `in_data`  in  DATA_WIDTH  accelerator output word.
- `in_strb`  in  DATA_WIDTH/8  byte strobes, stored alongside the data.
- `in_ready`  out  1  = !full; informational only, because the producer ignores it.
- `out_valid`  out  1  = !empty.
- `out_data`  out  DATA_WIDTH  head entry data.
- `out_strb`  out  DATA_WIDTH/8  head entry strobes.
- `out_ready`  in  1  consumer ready.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when the job completes.
- `overflow`  out  1  sticky; a beat was dropped.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `delivered`  out  CNT_WIDTH  output handshakes counted in the current job.

## Operation
- **FIFO storage.** Registered memory of DEPTH x (DATA_WIDTH + DATA_WIDTH/8). Read and write pointers are $clog2(DEPTH) bits and wrap naturally. The occupancy counter `level` ranges 0..DEPTH.
- **Push.** Occurs when `in_valid && !full`, where `full` is the registered value from the start of the cycle.
- **Push while full.** `in_valid && full` drops the beat and sets `overflow`. This holds even if a pop happens in the same cycle.
- **Pop.** Occurs on `out_valid && out_ready`.
- **Simultaneous push and pop.** `level` is unchanged and both pointers advance.
- **Output path.** First-word-fall-through: `out_data`/`out_strb` are read from `mem[rd_ptr]`. Head values are stable while `out_valid && !out_ready`.
- **Independence from the FSM.** Push and pop operate in every FSM state; the FSM only governs counting and `done`.
- **FSM states:** IDLE, RUN, FIN.
  - IDLE: on `start`, latch `expected_beats` and clear `delivered`. Go to RUN if the latched value is non-zero, otherwise go to FIN.
  - RUN: each pop increments `delivered`. When a pop makes `delivered == expected` (the latched value), go to FIN. Pops beyond `expected` cannot occur in RUN; after FIN they are not counted.
  - FIN: `done` = 1 for exactly this one cycle, then return to IDLE. `delivered` holds its final value until the next accepted `start` or `clear`.
- **Start outside IDLE.** `start` is ignored in RUN and FIN.
- **Priority.** `reset` beats `clear`, which beats `start`/push/pop. A push or pop in a `clear` cycle has no effect.
- **Counter width.** `delivered` never wraps, because it stops at `expected` ≤ 2^CNT_WIDTH − 1.

## Timing
- **Reset values:** `out_valid`=0, `out_data`/`out_strb` = contents of entry 0 (don't-care, not checked), `in_ready`=1, `busy`=0, `done`=0, `overflow`=0, `level`=0, `delivered`=0, FSM in IDLE.
- **Latency.** A push in cycle N into an empty FIFO gives `out_valid`=1 and `out_data` = that word in cycle N+1. There is no combinational path from `in_*` to `out_*`.
- **Ready-to-valid path.** `out_ready` affects `out_valid` only in the next cycle.
- **Throughput.** One beat per cycle in and out sustained, with `level` constant.
- **Start timing.**
  - An accepted `start` in cycle N gives `busy`=1 from N+1.
  - The final pop in cycle M gives `done`=1 in M+1 and `busy`=0 from M+1.
  - `expected_beats`=0 gives `done` in N+1.
- **Flag timing.**
  - `overflow` is set the cycle after the dropped beat.
  - `full`/`in_ready` update the cycle after a push.

## Test plan
- **Basic job.** After reset, `start` with `expected_beats`=4; push 0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00 back-to-back with `out_ready`=1 → the words appear in order, each one cycle after its push. `delivered` reaches 4 and `done` pulses once, the cycle after the 4th pop. `overflow`=0.
- **Back-pressure.** Hold `out_ready`=0 and push 8 beats → `level`=8, `in_ready`=0, head stays at beat 0. Push a 9th beat (0xDEADBEEF) → it is dropped, `overflow`=1, `level`=8. Release ready → exactly beats 0..7 drain.
- **Full with concurrent pop.** With `level`=8, push and pop in the same cycle → the push is dropped, `overflow` is set, `level`=7.
- **Wrap-around.** 20 beats with `out_ready` toggling 1,0,1,… → all 20 are delivered in order across pointer wrap. `done` fires for `expected`=20 and `level` returns to 0.
- **Zero-length job and start filtering.** `start` with `expected_beats`=0 → `done` the next cycle, `busy` never set. A `start` issued during RUN is ignored, and `expected` keeps its original value.
- **Clear and reset mid-job.** With `level`=3 in RUN:
  - `clear` → `level`=0, `out_valid`=0, `delivered`=0, `overflow`=0, IDLE, no `done`.
  - Repeat with async `reset` asserted mid-cycle → outputs reach their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/output_stream_buffer.sv
// rtl/output_stream_buffer.sv - elastic FIFO between accelerator output and streamer, with job beat counting
module output_stream_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       start,
  input  logic [CNT_WIDTH-1:0]       expected_beats,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic [DATA_WIDTH/8-1:0]    in_strb,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [DATA_WIDTH/8-1:0]    out_strb,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_WIDTH-1:0]       delivered
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_WIDTH + STRB_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 overflow_q, overflow_d;

  state_t               state_q;
  logic [CNT_WIDTH-1:0] expected_q;
  logic [CNT_WIDTH-1:0] delivered_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 drop;

  // Full/empty come straight from the registered occupancy, so no input reaches an output combinationally.
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

  // The producer cannot be stalled: a beat arriving while full is lost, even if a pop frees a slot this cycle.
  assign push = in_valid && !full && !clear;
  assign pop  = !empty && out_ready && !clear;
  assign drop = in_valid && full;

  // Next-state of pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are meaningless until written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_strb, in_data};
    end
  end

  // Job FSM: counts pops against the latched total and produces a single-cycle done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      expected_q  <= '0;
      delivered_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (clear) begin
      state_q     <= S_IDLE;
      expected_q  <= '0;
      delivered_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            expected_q  <= expected_beats;
            delivered_q <= '0;
            if (expected_beats != '0) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (pop) begin
            delivered_q <= delivered_q + CNT_WIDTH'(1);
            if ((delivered_q + CNT_WIDTH'(1)) == expected_q) begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign out_strb  = mem_q[rd_ptr_q][ENTRY_W-1:DATA_WIDTH];
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign level     = level_q;
  assign delivered = delivered_q;

endmodule

// File: tb/tb_output_stream_buffer.sv
// tb/tb_output_stream_buffer.sv - randomized and directed check of output_stream_buffer against a queue model
module tb_output_stream_buffer;

  localparam int DW = 32;
  localparam int SW = 4;
  localparam int DEPTH = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] expected_beats = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [SW-1:0] in_strb = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_strb;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [3:0]    level;
  logic [CW-1:0] delivered;

  output_stream_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start),
    .expected_beats(expected_beats), .in_valid(in_valid), .in_data(in_data),
    .in_strb(in_strb), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_strb(out_strb), .out_ready(out_ready),
    .busy(busy), .done(done), .overflow(overflow), .level(level),
    .delivered(delivered)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of {strb,data}, a job-in-progress flag and a done-this-cycle flag.
  logic [DW+SW-1:0] mq[$];
  bit m_ovf = 0;
  bit m_active = 0;
  bit m_done = 0;
  int m_exp = 0;
  int m_del = 0;
  bit m_pop, m_push, m_drop, m_done_nx;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete(); m_ovf = 0; m_active = 0; m_done = 0; m_del = 0; m_exp = 0;
    end else if (clear) begin
      mq.delete(); m_ovf = 0; m_active = 0; m_done = 0; m_del = 0;
    end else begin
      m_pop  = (mq.size() > 0) && out_ready;
      m_push = in_valid && (mq.size() < DEPTH);
      m_drop = in_valid && (mq.size() == DEPTH);
      m_done_nx = 0;
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back({in_strb, in_data});
      if (m_drop) m_ovf = 1;
      if (!m_active && !m_done) begin
        if (start) begin
          m_exp = int'(expected_beats);
          m_del = 0;
          if (m_exp == 0) m_done_nx = 1;
          else m_active = 1;
        end
      end else if (m_active && m_pop) begin
        m_del++;
        if (m_del == m_exp) begin
          m_active = 0;
          m_done_nx = 1;
        end
      end
      m_done = m_done_nx;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("out_data", out_data, mq[0][DW-1:0]);
        chk("out_strb", out_strb, mq[0][DW+SW-1:DW]);
      end
      chk("in_ready", in_ready, mq.size() < DEPTH);
      chk("level", level, mq.size());
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      chk("overflow", overflow, m_ovf);
      chk("delivered", delivered, m_del);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [DW-1:0] words [4];
  logic [DW-1:0] bp [8];
  int pushed;
  bit got;

  initial begin
    words[0] = 32'h11223344; words[1] = 32'h55667788;
    words[2] = 32'h99AABBCC; words[3] = 32'hDDEEFF00;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_level", level, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);

    // Basic job
    start = 1; expected_beats = 4; tick(); start = 0;
    chk("basic_busy", busy, 1);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = words[i]; in_strb = 4'hF; tick();
      chk("basic_head", out_data, words[i]);
      chk("basic_valid", out_valid, 1);
    end
    in_valid = 0; tick();
    chk("basic_done", done, 1);
    chk("basic_delivered", delivered, 4);
    chk("basic_busy_off", busy, 0);
    tick();
    chk("basic_done_once", done, 0);
    chk("basic_ovf", overflow, 0);

    // Back-pressure and overflow
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      bp[i] = $urandom; in_valid = 1; in_data = bp[i]; in_strb = 4'(i); tick();
    end
    chk("bp_level", level, 8);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_head", out_data, bp[0]);
    in_data = 32'hDEADBEEF; tick();
    chk("bp_ovf", overflow, 1);
    chk("bp_level_drop", level, 8);
    // Full with a concurrent pop: push still dropped
    out_ready = 1; in_data = 32'hCAFEF00D; tick();
    chk("fullpop_level", level, 7);
    chk("fullpop_head", out_data, bp[1]);
    in_valid = 0;
    for (int i = 1; i < 8; i++) begin
      chk("drain_head", out_data, bp[i]);
      tick();
    end
    chk("drain_empty", out_valid, 0);
    clear = 1; tick(); clear = 0;
    chk("clear_ovf", overflow, 0);

    // Wrap-around with toggling ready
    start = 1; expected_beats = 20; tick(); start = 0;
    pushed = 0; got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      out_ready = (i % 2 == 0);
      in_valid = (i % 3 == 0) && (pushed < 20);
      in_data = $urandom; in_strb = 4'($urandom);
      if (in_valid) pushed++;
      tick();
      if (done) got = 1;
    end
    in_valid = 0;
    chk("wrap_done", got, 1);
    chk("wrap_level", level, 0);
    chk("wrap_delivered", delivered, 20);
    chk("wrap_ovf", overflow, 0);
    tick();

    // Zero-length job
    start = 1; expected_beats = 0; tick(); start = 0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    tick();
    chk("zero_done_once", done, 0);

    // Start during RUN is ignored
    out_ready = 1;
    start = 1; expected_beats = 3; tick();
    chk("filt_busy", busy, 1);
    expected_beats = 1; in_valid = 1; in_data = 32'hA0A0A0A0; tick(); start = 0;
    in_data = 32'hB0B0B0B0; tick();
    chk("filt_no_early_done", done, 0);
    chk("filt_del1", delivered, 1);
    in_data = 32'hC0C0C0C0; tick();
    in_valid = 0; tick();
    chk("filt_done", done, 1);
    chk("filt_del3", delivered, 3);
    tick();

    // Clear mid-job
    out_ready = 0;
    start = 1; expected_beats = 10; tick(); start = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = $urandom; tick();
    end
    in_valid = 0;
    chk("mid_level", level, 3);
    clear = 1; tick(); clear = 0;
    chk("clr_level", level, 0);
    chk("clr_valid", out_valid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_delivered", delivered, 0);
    tick();
    chk("clr_no_done", done, 0);

    // Asynchronous reset mid-job
    start = 1; expected_beats = 10; tick(); start = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = $urandom; tick();
    end
    in_valid = 0;
    #1 reset = 1;
    #1;
    chk("arst_level", level, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 1);
    tick();
    reset = 0;
    tick();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_data = $urandom; in_strb = 4'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      start = ($urandom_range(0, 7) == 0);
      expected_beats = CW'($urandom_range(0, 12));
      clear = ($urandom_range(0, 63) == 0);
      tick();
    end
    start = 0; clear = 0; in_valid = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
